// File: rtl/hazard_ctrl_pkg.sv
// hazard_pkg: shared state encoding and constants for the hazard control unit
package hazard_pkg;
    typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int MC_CNT_W = 8;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side hazard inputs and control strobes/counters
interface hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             id_uses_rt_i;
    logic             ex_mem_read_i;
    logic [4:0]       ex_rt_i;
    logic             mc_start_i;
    logic             jump_i;
    logic             branch_taken_i;
    logic             pc_write_o;
    logic             ifid_stall_o;
    logic             ifid_flush_o;
    logic             idex_stall_o;
    logic             idex_flush_o;
    logic             exmem_flush_o;
    logic             mc_done_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_rt_i, mc_start_i, jump_i, branch_taken_i,
        input  pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o, exmem_flush_o, mc_done_o,
               stall_cnt_o, flush_cnt_o
    );
    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_rt_i, mc_start_i, jump_i, branch_taken_i,
        output pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o, exmem_flush_o, mc_done_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(parameter int W = 16) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    // count events, holding at the maximum value
    always_ff @(posedge clk_i or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else if (inc_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush generation for load-use, branch, jump and multi-cycle EX hazards
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic         clk_i,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus
);
    state_t              state_q, state_d;
    logic [MC_CNT_W-1:0] cnt_q, cnt_d;
    logic lu, pc, ifid_s, ifid_f, idex_s, idex_f, exmem_f, done, flush_inc;
    assign lu = bus.ex_mem_read_i && bus.ex_rt_i != REG_ZERO &&
                (bus.ex_rt_i == bus.id_rs_i || (bus.id_uses_rt_i && bus.ex_rt_i == bus.id_rt_i));
    // FSM state and multi-cycle countdown
    always_ff @(posedge clk_i or negedge rst_n)
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    // prioritised hazard resolution: branch, MC wait, MC done/start, load-use, jump, run
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        {pc, ifid_s, ifid_f, idex_s, idex_f, exmem_f, done, flush_inc} = '0;
        if (bus.branch_taken_i) begin
            {pc, ifid_f, idex_f, exmem_f, flush_inc} = '1;
            state_d = RUN;
            cnt_d = '0;
        end else if (state_q == MC_WAIT && cnt_q > 1) begin
            {ifid_s, idex_s, exmem_f} = '1;
            cnt_d = cnt_q - 1'b1;
        end else begin
            if (state_q == MC_WAIT) begin
                done = 1'b1;
                state_d = RUN;
                cnt_d = '0;
            end
            if (state_q == RUN && bus.mc_start_i) begin
                {ifid_s, idex_s, exmem_f} = '1;
                cnt_d = MC_CNT_W'(MC_LAT - 1);
                state_d = MC_WAIT;
            end else if (lu) begin
                {ifid_s, idex_f} = '1;
            end else if (bus.jump_i) begin
                {pc, ifid_f} = '1;
            end else begin
                pc = 1'b1;
            end
        end
    end
    assign bus.pc_write_o    = rst_n & pc;
    assign bus.ifid_stall_o  = rst_n & ifid_s;
    assign bus.ifid_flush_o  = rst_n & ifid_f;
    assign bus.idex_stall_o  = rst_n & idex_s;
    assign bus.idex_flush_o  = rst_n & idex_f;
    assign bus.exmem_flush_o = rst_n & exmem_f;
    assign bus.mc_done_o     = rst_n & done;
    sat_counter #(.W(CNT_W)) u_stall_cnt (.clk_i(clk_i), .rst_n(rst_n), .inc_i(!pc), .cnt_o(bus.stall_cnt_o));
    sat_counter #(.W(CNT_W)) u_flush_cnt (.clk_i(clk_i), .rst_n(rst_n), .inc_i(flush_inc), .cnt_o(bus.flush_cnt_o));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a cycle-indexed model
module tb_hazard_ctrl;
    localparam int MC_LAT = 4;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;
    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   md_at = -1;
    int   m_stall = 0;
    int   m_flush = 0;
    hazard_ctrl_if #(.CNT_W(CNT_W)) h();
    hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (.clk_i(clk_i), .rst_n(rst_n), .bus(h));
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {h.pc_write_o, h.ifid_stall_o, h.ifid_flush_o, h.idex_stall_o,
                h.idex_flush_o, h.exmem_flush_o, h.mc_done_o};
    endfunction

    task automatic drive(input logic br, st, jp, mr, ur, input logic [4:0] ert, rs, rt);
        h.branch_taken_i = br;
        h.mc_start_i = st;
        h.jump_i = jp;
        h.ex_mem_read_i = mr;
        h.id_uses_rt_i = ur;
        h.ex_rt_i = ert;
        h.id_rs_i = rs;
        h.id_rt_i = rt;
    endtask

    // One pipeline cycle: apply inputs mid-cycle, compare against the model, advance the model.
    // The model tracks the cycle index at which an outstanding multi-cycle op completes.
    task automatic step(input logic br, st, jp, mr, ur, input logic [4:0] ert, rs, rt);
        logic [6:0] e;
        logic lu, waiting;
        @(negedge clk_i);
        drive(br, st, jp, mr, ur, ert, rs, rt);
        #1;
        lu = mr && ert != 0 && (ert == rs || (ur && ert == rt));
        waiting = md_at >= 0;
        if (br) begin
            e = 7'b1010110;
            md_at = -1;
        end else if (waiting && cyc < md_at) begin
            e = 7'b0101010;
        end else begin
            md_at = -1;
            if (!waiting && st) begin
                e = 7'b0101010;
                md_at = cyc + MC_LAT - 1;
            end else if (lu) e = 7'b0100100;
            else if (jp) e = 7'b1010000;
            else e = 7'b1000000;
            e[0] = waiting;
        end
        chk("strobes", 32'(strobes()), 32'(e));
        chk("stall_cnt", 32'(h.stall_cnt_o), 32'(m_stall));
        chk("flush_cnt", 32'(h.flush_cnt_o), 32'(m_flush));
        if (!e[6] && m_stall < CMAX) m_stall++;
        if (br && m_flush < CMAX) m_flush++;
        cyc++;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_strobes", 32'(strobes()), 32'd0);
        chk("rst_stall_cnt", 32'(h.stall_cnt_o), 32'd0);
        chk("rst_flush_cnt", 32'(h.flush_cnt_o), 32'd0);
        md_at = -1;
        m_stall = 0;
        m_flush = 0;
        @(negedge clk_i);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        do_reset();
        // load-use on rs, then register zero never hazards
        step(0, 0, 0, 1, 0, 5'd8, 5'd8, 5'd3);
        chk("lu_pc", 32'(h.pc_write_o), 32'd0);
        step(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        chk("r0_pc", 32'(h.pc_write_o), 32'd1);
        step(0, 0, 0, 1, 1, 5'd9, 5'd1, 5'd9);
        step(0, 0, 0, 1, 0, 5'd9, 5'd1, 5'd9);
        // full multi-cycle op
        do_reset();
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle();
        idle();
        idle();
        chk("mc_done", 32'(h.mc_done_o), 32'd1);
        chk("mc_done_pc", 32'(h.pc_write_o), 32'd1);
        chk("mc_stall_cnt", 32'(h.stall_cnt_o), 32'd3);
        idle();
        // branch aborts MC_WAIT when two cycles remain
        do_reset();
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle();
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        chk("br_done", 32'(h.mc_done_o), 32'd0);
        idle();
        chk("br_flush_cnt", 32'(h.flush_cnt_o), 32'd1);
        chk("br_run_pc", 32'(h.pc_write_o), 32'd1);
        // load-use outranks jump, jump follows once the hazard clears
        step(0, 0, 1, 1, 0, 5'd4, 5'd4, 5'd0);
        step(0, 0, 1, 0, 0, 5'd4, 5'd4, 5'd0);
        chk("jmp_flush", 32'(h.ifid_flush_o), 32'd1);
        // stall counter saturation
        do_reset();
        repeat (20) step(0, 0, 0, 1, 0, 5'd5, 5'd5, 5'd0);
        idle();
        chk("sat_stall_cnt", 32'(h.stall_cnt_o), 32'(CMAX));
        // asynchronous reset in the middle of MC_WAIT
        do_reset();
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle();
        do_reset();
        idle();
        chk("post_rst_pc", 32'(h.pc_write_o), 32'd1);
        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(9) == 0, $urandom_range(7) == 0, $urandom_range(3) == 0,
                 $urandom_range(1) == 1, 1'($urandom), 5'($urandom_range(3)),
                 5'($urandom_range(3)), 5'($urandom_range(3)));
            if (i == 1500) do_reset();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
